mul_seq: RTL and testbench
==========================

# mul_seq

Multi-cycle MIPS MULT/MULTU unit that sequences the CPU's single-cycle 32-bit `add` adder through a 32-step shift-and-add loop to produce a 64-bit product into HI/LO. Sits beside the ALU in the execute stage. The core stalls on `busy` and captures `hi`/`lo` on `done`.

## Interface
- No parameters. Width is fixed at 32 to match `add`; the product is 64 bits.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a multiply; sampled only in IDLE
- `is_signed`  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with `start`
- `a`  in  32  multiplicand; sampled with `start`
- `b`  in  32  multiplier; sampled with `start`
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid
- `hi`  out  32  product[63:32]; held until the next accepted `start`
- `lo`  out  32  product[31:0]; held until the next accepted `start`

## Operation
- **States:** IDLE → PREP → RUN → FIX → DONE → IDLE.
- **IDLE:** on `start`, latch `a`, `b` and `is_signed`, set `busy`, go to PREP.
- **PREP:**
  - If signed, replace each operand with its magnitude (negative → ~x+1); 0x80000000 stays 0x80000000 as unsigned 2^31.
  - Record `neg` = sign(a) XOR sign(b), signed mode only.
  - Clear accumulator P = {hi_acc, lo_acc} = 0; load the multiplier into lo_acc; step counter = 0.
- **RUN, 32 iterations, one per cycle:**
  - If lo_acc[0] = 1, compute sum = hi_acc + mcand via one `add` instance; otherwise the addend is 0.
  - Carry out = (x[31]&y[31]) | ((x[31]|y[31]) & ~sum[31]). The overflow output `o` of `add` is unused.
  - Shift {carry, sum, lo_acc} right by 1 into {hi_acc, lo_acc}.
  - Counter 5 bits, increments each step; leave RUN after the step where the counter is 31 (wraps to 0).
- **FIX:** if `neg`, P = ~P + 1 (64-bit). Write P to the `hi`/`lo` registers.
- **DONE:** `done` = 1 and `busy` = 0 for one cycle, then IDLE.
- **Simultaneous events:**
  - `start` while not in IDLE is ignored; it is not queued.
  - `start` during the DONE cycle is also ignored. A new operation is accepted in IDLE, at the earliest one cycle after `done`.
- **Reset:** asserting `rst_n` low at any time, including mid-RUN, immediately gives IDLE, `busy` = 0, `done` = 0, `hi` = `lo` = 0, and clears internal registers. No partial result is ever exposed.

## Timing
- **Reset values:** `busy` 0, `done` 0, `hi` 0x00000000, `lo` 0x00000000.
- **Edge E0 samples `start`:**
  - PREP occupies E0..E1.
  - RUN steps complete at edges E2..E33.
  - FIX completes at E34.
  - `done` is high from E35 to E36.
- **Latency:** 35 cycles from accept to `done`; data-independent, with no early termination.
- **Outputs:**
  - `busy` is high from E0 to E35; it is low in the DONE cycle.
  - `hi`/`lo` change only at the FIX edge (E34) or at reset. They keep the previous result while a new operation runs.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `mul_pkg`:**
  - state enum (IDLE, PREP, RUN, FIX, DONE), 3-bit encoding
  - `MUL_STEPS` = 32
  - `MUL_LATENCY` = 35 (for the bench)
- **Sub-module:** exactly one instance of the existing 32-bit `add` (ports `a`, `b`, `r`, `o`) for the per-step partial-sum addition.
- The 64-bit negation in FIX and the magnitude step in PREP are inline logic, not extra adder instances.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` at E35; `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- MULT 0xFFFFFFFD (−3) × 0x00000005 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. MULT 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0x00000000, `lo` = 0x00000001.
- MULT 0x80000000 × 0x80000000 → `hi` = 0x40000000, `lo` = 0. MULTU 0x80000000 × 0x00000002 → `hi` = 0x00000001, `lo` = 0.
- `start` pulsed at E10 and during the DONE cycle with different operands → ignored; the first result is unchanged and `busy` is unaffected. Then `start` in IDLE is accepted normally.
- `rst_n` low at E20 of an operation → `busy`, `done`, `hi`, `lo` all 0 asynchronously. After release, 0x00001234 × 0x00000010 MULTU → `lo` = 0x00012340 at E35.
- Randomised 1000 operands of both signednesses vs. a 64-bit reference model. Checks: `busy` width is exactly 35 cycles, `done` width is exactly 1 cycle, and `hi`/`lo` are stable between FIX edges.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, constants and helpers for the sequential multiplier
package mul_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mul_state_e;

  // One shift-and-add step per multiplier bit
  localparam int MUL_STEPS   = 32;
  // Clock cycles from the accepting edge to the first edge at which done is visible
  localparam int MUL_LATENCY = 35;

  // Magnitude of an operand. In unsigned mode the operand passes through.
  // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    if (is_signed && x[31]) begin
      return ~x + 32'd1;
    end
    return x;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - request/result bundle between the core and the multiplier
interface mul_seq_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // The core issues requests and consumes results
  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  // The multiplier accepts requests and produces results
  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/add.sv
// rtl/add.sv - 32-bit single-cycle adder shared with the ALU
module add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] r,
  output logic        o
);

  // Sum plus two's-complement overflow flag
  assign r = a + b;
  assign o = (a[31] == b[31]) && (r[31] != a[31]);

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - multi-cycle MULT/MULTU unit built on a 32-step shift-and-add loop
module mul_seq
  import mul_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);

  mul_state_e  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_acc_q, hi_acc_d;
  logic [31:0] lo_acc_q, lo_acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic        neg_q, neg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        carry;
  logic [63:0] fix_prod;
  logic        unused_add_o;

  // Requests are taken only in IDLE, and not in the cycle where done is still showing
  assign accept = (state_q == S_IDLE) && bus.start && !done_q;

  // Partial sum: add the multiplicand only when the current multiplier bit is set
  assign addend = lo_acc_q[0] ? mcand_q : 32'd0;

  add u_add (
    .a (hi_acc_q),
    .b (addend),
    .r (sum),
    .o (unused_add_o)
  );

  // Unsigned carry out of the 32-bit add, recovered from the operand and sum MSBs
  assign carry = (hi_acc_q[31] & addend[31]) | ((hi_acc_q[31] | addend[31]) & ~sum[31]);

  // Final sign correction on the full 64-bit accumulator
  assign fix_prod = neg_q ? (~{hi_acc_q, lo_acc_q} + 64'd1) : {hi_acc_q, lo_acc_q};

  // Next-state, datapath and output logic for the sequencer
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    hi_acc_d = hi_acc_q;
    lo_acc_d = lo_acc_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = bus.a;
          lo_acc_d = bus.b;
          signed_d = bus.is_signed;
          busy_d   = 1'b1;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        mcand_d  = mag32(mcand_q, signed_q);
        lo_acc_d = mag32(lo_acc_q, signed_q);
        neg_d    = signed_q & (mcand_q[31] ^ lo_acc_q[31]);
        hi_acc_d = 32'd0;
        cnt_d    = 5'd0;
        busy_d   = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        hi_acc_d = {carry, sum[31:1]};
        lo_acc_d = {sum[0], lo_acc_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        busy_d   = 1'b1;
        if (cnt_q == 5'(MUL_STEPS - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        hi_d    = fix_prod[63:32];
        lo_d    = fix_prod[31:0];
        busy_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wipes everything, including any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'd0;
      hi_acc_q <= 32'd0;
      lo_acc_q <= 32'd0;
      cnt_q    <= 5'd0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      hi_acc_q <= hi_acc_d;
      lo_acc_q <= lo_acc_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq against a 64-bit arithmetic model
module tb_mul_seq;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  mul_seq_if bus();

  mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit inj, input string tag);
    logic [31:0] old_hi, old_lo;
    logic [63:0] exp;
    int          lat, bcnt;
    bit          stable;
    exp = ref_mul(a, b, s);
    @(negedge clk);
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.is_signed = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    bcnt = 0;
    stable = 1'b1;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bcnt++;
      if (lat < 34 && (bus.hi !== old_hi || bus.lo !== old_lo)) stable = 1'b0;
      if (inj && lat == 9) begin
        bus.start = 1'b1;
        bus.a = ~a;
        bus.b = b + 32'd1;
        bus.is_signed = ~s;
      end
      if (inj && lat == 10) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(MUL_LATENCY));
    check({tag, " busy_width"}, 64'(bcnt), 64'(MUL_LATENCY));
    check({tag, " busy_low_in_done"}, 64'(bus.busy), 64'd0);
    check({tag, " hilo_stable"}, 64'(stable), 64'd1);
    check({tag, " product"}, {bus.hi, bus.lo}, exp);
    if (inj) begin
      bus.start = 1'b1;
      bus.a = 32'h0000_0007;
      bus.b = 32'h0000_0009;
      bus.is_signed = 1'b0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " done_width"}, 64'(bus.done), 64'd0);
    if (inj) begin
      check({tag, " start_in_done_ignored"}, 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      check({tag, " still_idle"}, 64'(bus.busy), 64'd0);
      check({tag, " result_kept"}, {bus.hi, bus.lo}, exp);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_ff");
    check("multu_ff hi const", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_ff lo const", 64'(bus.lo), 64'h0000_0001);
    do_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0, "mult_m3x5");
    check("mult_m3x5 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "mult_m1m1");
    check("mult_m1m1 const", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "mult_min_min");
    check("mult_min_min const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    do_op(32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0, "multu_min_x2");
    check("multu_min_x2 const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    do_op(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, "mult_zero");

    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, "inject");
    do_op(32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 1'b0, "after_inject");

    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h7654_3210;
    bus.b = 32'h0FED_CBA9;
    bus.is_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset busy", 64'(bus.busy), 64'd0);
    check("midrun_reset done", 64'(bus.done), 64'd0);
    check("midrun_reset hi", 64'(bus.hi), 64'd0);
    check("midrun_reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0, "post_reset");
    check("post_reset lo const", 64'(bus.lo), 64'h0001_2340);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, 1'b0, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
